// File: rtl/rect_glyph_engine.sv
// Runtime-loadable rectangle table with per-pixel hit queries, blink and clear.
// Two-stage query pipeline between the VGA pixel counter and the colour mux.
module rect_glyph_engine #(
    parameter int NUM_RECTS    = 64,
    parameter int COORD_W      = 10,
    parameter int SET_W        = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_RECTS)-1:0] wr_idx,
    input  logic [COORD_W-1:0]           wr_row,
    input  logic [COORD_W-1:0]           wr_col,
    input  logic [COORD_W-1:0]           wr_height,
    input  logic [COORD_W-1:0]           wr_width,
    input  logic [SET_W-1:0]             wr_set,
    input  logic                         clr_req,
    output logic                         busy,
    input  logic [SET_W-1:0]             set_sel,
    input  logic                         blink_en,
    input  logic                         frame_tick,
    input  logic                         q_valid,
    input  logic [COORD_W-1:0]           q_row,
    input  logic [COORD_W-1:0]           q_col,
    output logic                         hit_valid,
    output logic                         hit,
    output logic [$clog2(NUM_RECTS)-1:0] hit_idx,
    output logic                         visible
);
    localparam int IW = $clog2(NUM_RECTS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {IDLE, CLEARING} state_e;

    state_e state_q, state_d;
    logic [IW-1:0] clr_cnt_q, clr_cnt_d;

    logic [COORD_W-1:0] row_q [NUM_RECTS];
    logic [COORD_W-1:0] col_q [NUM_RECTS];
    logic [COORD_W-1:0] hgt_q [NUM_RECTS];
    logic [COORD_W-1:0] wid_q [NUM_RECTS];
    logic [SET_W-1:0]   set_q [NUM_RECTS];
    logic [NUM_RECTS-1:0] valid_q;

    logic [NUM_RECTS-1:0] match;
    logic [NUM_RECTS-1:0] match_s1_q;
    logic                 vis_s1_q;
    logic                 v_s1_q;
    logic                 hit_q;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 hv_q;

    logic [BW-1:0] blink_cnt_q;
    logic          visible_q;
    logic          wr_ok;

    // A clear request in the same cycle wins over a write.
    assign wr_ok = wr_en && (state_q == IDLE) && !clr_req;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEARING;
                    clr_cnt_d = '0;
                end
            end
            CLEARING: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IW'(NUM_RECTS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            row_q[wr_idx] <= wr_row;
            col_q[wr_idx] <= wr_col;
            hgt_q[wr_idx] <= wr_height;
            wid_q[wr_idx] <= wr_width;
            set_q[wr_idx] <= wr_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (wr_ok) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (state_q == CLEARING) begin
                valid_q[clr_cnt_q] <= 1'b0;
            end
        end
    end

    // End sums are one bit wider so rectangles near the edge never wrap.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            match[i] = valid_q[i] && (set_q[i] == set_sel)
                && (q_row >= row_q[i])
                && ({1'b0, q_row} < ({1'b0, row_q[i]} + {1'b0, hgt_q[i]}))
                && (q_col >= col_q[i])
                && ({1'b0, q_col} < ({1'b0, col_q[i]} + {1'b0, wid_q[i]}));
        end
    end

    always_comb begin
        idx_d = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (match_s1_q[i]) begin
                idx_d = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_s1_q     <= 1'b0;
            match_s1_q <= '0;
            vis_s1_q   <= 1'b0;
            hv_q       <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            v_s1_q <= q_valid;
            if (q_valid) begin
                match_s1_q <= match;
                vis_s1_q   <= visible_q && (state_q == IDLE);
            end
            hv_q <= v_s1_q;
            if (v_s1_q) begin
                hit_q <= vis_s1_q && (|match_s1_q);
                idx_q <= idx_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                visible_q   <= ~visible_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign busy      = (state_q == CLEARING);
    assign hit_valid = hv_q;
    assign hit       = hit_q;
    assign hit_idx   = idx_q;
    assign visible   = visible_q;
endmodule

// File: tb/tb_rect_glyph_engine.sv
// Randomised bench for rect_glyph_engine against a behavioural table model.
// Expected results come from plain geometry on the modelled rectangle list.
module tb_rect_glyph_engine;
    localparam int NR = 64;
    localparam int CW = 10;
    localparam int SW = 1;
    localparam int BF = 2;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wr_row, wr_col, wr_height, wr_width;
    logic [SW-1:0] wr_set;
    logic          clr_req;
    logic          busy;
    logic [SW-1:0] set_sel;
    logic          blink_en;
    logic          frame_tick;
    logic          q_valid;
    logic [CW-1:0] q_row, q_col;
    logic          hit_valid;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          visible;

    always #5 clk = ~clk;

    rect_glyph_engine #(
        .NUM_RECTS(NR), .COORD_W(CW), .SET_W(SW), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_row(wr_row), .wr_col(wr_col),
        .wr_height(wr_height), .wr_width(wr_width), .wr_set(wr_set),
        .clr_req(clr_req), .busy(busy), .set_sel(set_sel),
        .blink_en(blink_en), .frame_tick(frame_tick),
        .q_valid(q_valid), .q_row(q_row), .q_col(q_col),
        .hit_valid(hit_valid), .hit(hit), .hit_idx(hit_idx),
        .visible(visible)
    );

    typedef struct {
        int due;
        int hit;
        int idx;
    } exp_t;

    int   m_valid [NR];
    int   m_r [NR];
    int   m_c [NR];
    int   m_h [NR];
    int   m_w [NR];
    int   m_s [NR];
    int   m_busy;
    int   m_vis;
    int   m_tick;
    int   cyc;
    exp_t sq [$];
    int   n_cmp;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Lowest-index rectangle of the selected set containing the pixel.
    task automatic ref_q(input int r, input int c, input int s,
                         output int h, output int idx);
        int found;
        found = 0;
        idx   = 0;
        for (int i = 0; i < NR; i++) begin
            if (found == 0 && m_valid[i] != 0 && m_s[i] == s
                && r >= m_r[i] && r < m_r[i] + m_h[i]
                && c >= m_c[i] && c < m_c[i] + m_w[i]) begin
                found = 1;
                idx   = i;
            end
        end
        h = (found != 0 && m_vis != 0 && m_busy == 0) ? 1 : 0;
    endtask

    task automatic model_wipe();
        for (int i = 0; i < NR; i++) m_valid[i] = 0;
    endtask

    task automatic step();
        exp_t e;
        int   h, ix, expv;
        if (q_valid) begin
            ref_q(int'(q_row), int'(q_col), int'(set_sel), h, ix);
            e.due = cyc + 2;
            e.hit = h;
            e.idx = ix;
            sq.push_back(e);
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (clr_req) begin
            m_busy = NR;
            model_wipe();
        end else if (wr_en) begin
            m_valid[wr_idx] = 1;
            m_r[wr_idx] = int'(wr_row);
            m_c[wr_idx] = int'(wr_col);
            m_h[wr_idx] = int'(wr_height);
            m_w[wr_idx] = int'(wr_width);
            m_s[wr_idx] = int'(wr_set);
        end
        if (!blink_en) begin
            m_tick = 0;
            m_vis  = 1;
        end else if (frame_tick) begin
            m_tick++;
            if (m_tick == BF) begin
                m_tick = 0;
                m_vis  = 1 - m_vis;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("busy", busy, (m_busy > 0) ? 1 : 0);
        chk("visible", visible, m_vis);
        expv = (sq.size() > 0 && sq[0].due == cyc) ? 1 : 0;
        chk("hit_valid", hit_valid, expv);
        if (expv != 0) begin
            e = sq.pop_front();
            chk("hit", hit, e.hit);
            if (e.hit != 0) chk("hit_idx", hit_idx, e.idx);
        end
    endtask

    task automatic wr(input int idx, input int r, input int c,
                      input int h, input int w, input int s);
        wr_en     = 1'b1;
        wr_idx    = IW'(idx);
        wr_row    = CW'(r);
        wr_col    = CW'(c);
        wr_height = CW'(h);
        wr_width  = CW'(w);
        wr_set    = SW'(s);
        step();
        wr_en = 1'b0;
    endtask

    task automatic qry(input int r, input int c);
        q_valid = 1'b1;
        q_row   = CW'(r);
        q_col   = CW'(c);
        step();
        q_valid = 1'b0;
    endtask

    task automatic rnd_wr_fields();
        wr_idx    = IW'($urandom_range(NR - 1));
        wr_row    = CW'($urandom_range(1023));
        wr_col    = CW'($urandom_range(1023));
        wr_height = CW'($urandom_range(300));
        wr_width  = CW'($urandom_range(300));
        wr_set    = SW'($urandom_range(1));
    endtask

    task automatic rnd_q();
        q_valid = ($urandom_range(3) != 0);
        q_row   = CW'($urandom_range(1023));
        q_col   = CW'($urandom_range(1023));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        sq.delete();
        model_wipe();
        m_busy = 0;
        m_vis  = 1;
        m_tick = 0;
        chk("rst_busy", busy, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_visible", visible, 1);
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    int vexp [5] = '{1, 1, 0, 0, 1};
    int bc;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        m_busy = 0; m_vis = 1; m_tick = 0;
        model_wipe();
        wr_en = 0; wr_idx = '0; wr_row = '0; wr_col = '0;
        wr_height = '0; wr_width = '0; wr_set = '0;
        clr_req = 0; set_sel = '0; blink_en = 0; frame_tick = 0;
        q_valid = 0; q_row = '0; q_col = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        wr(3, 60, 80, 20, 130, 0);
        qry(60, 80);
        qry(79, 209);
        qry(80, 80);
        repeat (2) step();

        wr(5, 90, 90, 20, 20, 0);
        wr(2, 95, 95, 10, 10, 0);
        qry(100, 100);
        wr(2, 95, 95, 10, 10, 1);
        qry(100, 100);
        repeat (2) step();

        wr(7, 1000, 1000, 30, 30, 0);
        qry(1023, 1023);
        wr(8, 10, 10, 0, 50, 0);
        wr(9, 10, 10, 50, 0, 0);
        qry(10, 10);
        qry(1000, 999);
        repeat (2) step();

        repeat (400) begin
            wr_en = ($urandom_range(3) == 0);
            rnd_wr_fields();
            set_sel = SW'($urandom_range(1));
            rnd_q();
            step();
        end
        wr_en = 0; q_valid = 0; set_sel = '0;
        repeat (2) step();

        clr_req = 1'b1;
        wr_en   = 1'b1;
        rnd_wr_fields();
        step();
        clr_req = 1'b0;
        bc = 1;
        for (int k = 0; k < NR + 4; k++) begin
            wr_en   = (k < NR - 1) && ($urandom_range(1) == 1);
            clr_req = (k == 10);
            rnd_wr_fields();
            q_valid = 1'b1;
            q_row   = CW'(70);
            q_col   = CW'($urandom_range(1023));
            step();
            if (busy) bc++;
        end
        chk("busy_len", bc, NR);
        wr_en = 0; clr_req = 0;
        repeat (40) begin
            rnd_q();
            set_sel = SW'($urandom_range(1));
            step();
        end
        q_valid = 0; set_sel = '0;
        repeat (2) step();

        wr(3, 60, 80, 20, 130, 0);
        blink_en = 1'b1;
        step();
        chk("blink_vis0", visible, vexp[0]);
        for (int t = 0; t < 4; t++) begin
            frame_tick = 1'b1;
            qry(70, 100);
            frame_tick = 1'b0;
            chk("blink_vis", visible, vexp[t + 1]);
            qry(70, 100);
            qry(61, 85);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        blink_en = 1'b0;
        qry(70, 100);
        repeat (2) step();

        repeat (300) begin
            wr_en      = ($urandom_range(3) == 0);
            rnd_wr_fields();
            clr_req    = ($urandom_range(99) == 0);
            blink_en   = ($urandom_range(7) != 0);
            frame_tick = ($urandom_range(2) == 0);
            set_sel    = SW'($urandom_range(1));
            rnd_q();
            step();
        end
        wr_en = 0; clr_req = 0; frame_tick = 0; blink_en = 0;
        q_valid = 0; set_sel = '0;
        repeat (NR + 2) step();

        wr(1, 0, 0, 500, 500, 0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        qry(10, 10);
        qry(20, 20);
        do_reset();
        repeat (20) begin
            rnd_q();
            step();
        end
        q_valid = 0;
        qry(10, 10);
        repeat (3) step();
        chk("queue_drained", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
